alu_arbiter: RTL and testbench

- Shares one combinational `alu` instance between two requesters, e.g. a front-panel operand sequencer and a debug/test requester.
- Each requester issues {op, porta, portb} on a valid/ready handshake.
- The arbiter grants one requester at a time in round-robin order and drives the ALU from registered operands.
- It captures out/zf/nf/of and returns them on that requester's own response handshake.

---
 rtl/alu_arbiter.sv | 174 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands are registered before driving the ALU; results return on a per-requester response handshake.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*OPW-1:0]     req_op,
  input  logic [2*WIDTH-1:0]   req_porta,
  input  logic [2*WIDTH-1:0]   req_portb,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_out,
  output logic                 rsp_zf,
  output logic                 rsp_nf,
  output logic                 rsp_of,
  output logic [OPW-1:0]       alu_op,
  output logic [WIDTH-1:0]     alu_porta,
  output logic [WIDTH-1:0]     alu_portb,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_zf,
  input  logic                 alu_nf,
  input  logic                 alu_of,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic             gnt_id_q, gnt_id_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zf_q, zf_d;
  logic             nf_q, nf_d;
  logic             of_q, of_d;

  logic             win_id;
  logic             accept;
  logic             rsp_hs;

  logic [OPW-1:0]   op_arr [2];
  logic [WIDTH-1:0] a_arr  [2];
  logic [WIDTH-1:0] b_arr  [2];

  // Unpack the concatenated requester buses into per-requester slices.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_arr[gi] = req_op[gi*OPW +: OPW];
      assign a_arr[gi]  = req_porta[gi*WIDTH +: WIDTH];
      assign b_arr[gi]  = req_portb[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // A lone requester always wins; a tie goes to the round-robin pointer.
  always_comb begin
    win_id = 1'b0;
    unique case (req_valid)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = rr_ptr_q;
      default: win_id = 1'b0;
    endcase
  end

  assign accept = (state_q == S_IDLE) && (req_valid != 2'b00);
  assign rsp_hs = (state_q == S_RESP) && rsp_ready[gnt_id_q];

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (accept) begin
      req_ready[win_id] = 1'b1;
    end
    if (state_q == S_RESP) begin
      rsp_valid[gnt_id_q] = 1'b1;
    end
  end

  assign busy = (state_q != S_IDLE);

  // Datapath next-state: latch on accept, capture during EXEC, advance pointer on handshake.
  always_comb begin
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    zf_d     = zf_q;
    nf_d     = nf_q;
    of_d     = of_q;
    if (accept) begin
      gnt_id_d = win_id;
      op_d     = op_arr[win_id];
      a_d      = a_arr[win_id];
      b_d      = b_arr[win_id];
    end
    if (state_q == S_EXEC) begin
      res_d = alu_out;
      zf_d  = alu_zf;
      nf_d  = alu_nf;
      of_d  = alu_of;
    end
    if (rsp_hs) begin
      rr_ptr_d = ~gnt_id_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt_id_q <= 1'b0;
      rr_ptr_q <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      of_q     <= of_d;
    end
  end

  // Holding registers drive the ALU directly, so it keeps its last operands between ops.
  assign alu_op    = op_q;
  assign alu_porta = a_q;
  assign alu_portb = b_q;
  assign rsp_out   = res_q;
  assign rsp_zf    = zf_q;
  assign rsp_nf    = nf_q;
  assign rsp_of    = of_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small behavioural ALU attached.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [1:0]        req_valid = 2'b00;
  logic [1:0]        req_ready;
  logic [3:0]        op0 = '0, op1 = '0;
  logic [31:0]       a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready = 2'b00;
  logic [31:0]       rsp_out;
  logic              rsp_zf, rsp_nf, rsp_of;
  logic [3:0]        alu_op;
  logic [31:0]       alu_porta, alu_portb;
  logic [31:0]       alu_out;
  logic              alu_zf, alu_nf, alu_of;
  logic              busy;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op({op1, op0}), .req_porta({a1, a0}), .req_portb({b1, b0}),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_zf(rsp_zf), .rsp_nf(rsp_nf), .rsp_of(rsp_of),
    .alu_op(alu_op), .alu_porta(alu_porta), .alu_portb(alu_portb),
    .alu_out(alu_out), .alu_zf(alu_zf), .alu_nf(alu_nf), .alu_of(alu_of),
    .busy(busy)
  );

  // Behavioural ALU: ADD/SUB with signed overflow, anything else passes porta.
  always_comb begin
    alu_out = alu_porta;
    alu_of  = 1'b0;
    if (alu_op == OP_ADD) begin
      alu_out = alu_porta + alu_portb;
      alu_of  = (alu_porta[31] == alu_portb[31]) && (alu_out[31] != alu_porta[31]);
    end else if (alu_op == OP_SUB) begin
      alu_out = alu_porta - alu_portb;
      alu_of  = (alu_porta[31] != alu_portb[31]) && (alu_out[31] != alu_porta[31]);
    end
    alu_zf = (alu_out == 32'h0);
    alu_nf = alu_out[31];
  end

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic apply_reset;
    tick;
    RST = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick;
    tick;
    RST = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (alu_op !== 4'h0) begin fails++; $display("FAIL reset_alu_op: got %h expected 0", alu_op); end
      tests++; if (rsp_out !== 32'h0) begin fails++; $display("FAIL reset_rsp_out: got %h expected 0", rsp_out); end
      tick;
    end
    $display("[TB] txn reset/idle checked");
  endtask

  task automatic test_single;
    apply_reset;
    tick;
    req_valid = 2'b01; op0 = OP_ADD; a0 = 32'h5; b0 = 32'h3; rsp_ready = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_accept: got %b expected 01", req_ready); end
    tick;
    req_valid = 2'b00;
    #1;
    tests++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin fails++; $display("FAIL single_exec: busy %b rsp_valid %b expected 1/00", busy, rsp_valid); end
    tests++; if (alu_op !== OP_ADD || alu_porta !== 32'h5 || alu_portb !== 32'h3) begin
      fails++; $display("FAIL single_alu_drive: got %h %h %h expected 2 5 3", alu_op, alu_porta, alu_portb); end
    tick; #1;
    tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid); end
    tests++; if (rsp_out !== 32'h8 || {rsp_zf, rsp_nf, rsp_of} !== 3'b000) begin
      fails++; $display("FAIL single_result: got %h zf/nf/of %b expected 8 000", rsp_out, {rsp_zf, rsp_nf, rsp_of}); end
    tick; #1;
    tests++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin fails++; $display("FAIL single_done: busy %b rsp_valid %b expected 0/00", busy, rsp_valid); end
    $display("[TB] txn req0 ADD 5+3 -> %h", rsp_out);
  endtask

  task automatic test_simultaneous;
    apply_reset;
    tick;
    req_valid = 2'b11; rsp_ready = 2'b11;
    op0 = OP_SUB; a0 = 32'h7; b0 = 32'h7;
    op1 = OP_ADD; a1 = 32'h7FFF_FFFF; b1 = 32'h1;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL simul_first_grant: got %b expected 01", req_ready); end
    tick;
    req_valid = 2'b10;
    #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL simul_exec_ready: got %b expected 00", req_ready); end
    tick; #1;
    tests++; if (rsp_valid !== 2'b01 || rsp_out !== 32'h0 || rsp_zf !== 1'b1) begin
      fails++; $display("FAIL simul_rsp0: got valid %b out %h zf %b expected 01 0 1", rsp_valid, rsp_out, rsp_zf); end
    $display("[TB] txn req0 SUB 7-7 -> %h", rsp_out);
    tick; #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL simul_second_grant: got %b expected 10", req_ready); end
    tick;
    req_valid = 2'b00;
    tick; #1;
    tests++; if (rsp_valid !== 2'b10 || rsp_out !== 32'h8000_0000 || {rsp_zf, rsp_nf, rsp_of} !== 3'b011) begin
      fails++; $display("FAIL simul_rsp1: got valid %b out %h zf/nf/of %b expected 10 80000000 011",
                        rsp_valid, rsp_out, {rsp_zf, rsp_nf, rsp_of}); end
    $display("[TB] txn req1 ADD 7fffffff+1 -> %h", rsp_out);
    tick;
    req_valid = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL simul_rr_ptr: got %b expected 01", req_ready); end
  endtask

  task automatic test_backpressure;
    apply_reset;
    tick;
    req_valid = 2'b10; op1 = OP_SUB; a1 = 32'h1; b1 = 32'h2; rsp_ready = 2'b00;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_accept: got %b expected 10", req_ready); end
    tick;
    req_valid = 2'b01; op0 = OP_ADD; a0 = 32'h1; b0 = 32'h1;
    #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_exec_ready: got %b expected 00", req_ready); end
    for (int c = 0; c < 6; c++) begin
      tick; #1;
      tests++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL bp_hold_valid: got %b expected 10", rsp_valid); end
      tests++; if (rsp_out !== 32'hFFFF_FFFF || rsp_nf !== 1'b1 || rsp_zf !== 1'b0) begin
        fails++; $display("FAIL bp_hold_data: got %h nf %b zf %b expected ffffffff 1 0", rsp_out, rsp_nf, rsp_zf); end
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_req0_blocked: got %b expected 00", req_ready); end
    end
    tick;
    rsp_ready = 2'b01;
    #1;
    tests++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL bp_wrong_ready_a: got %b expected 10", rsp_valid); end
    tick;
    rsp_ready = 2'b10;
    #1;
    tests++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL bp_wrong_ready_b: got %b expected 10", rsp_valid); end
    $display("[TB] txn req1 SUB 1-2 -> %h", rsp_out);
    tick;
    rsp_ready = 2'b11;
    #1;
    tests++; if (rsp_valid !== 2'b00 || req_ready !== 2'b01) begin
      fails++; $display("FAIL bp_release: got valid %b ready %b expected 00 01", rsp_valid, req_ready); end
    tick;
    req_valid = 2'b00;
    tick; #1;
    tests++; if (rsp_valid !== 2'b01 || rsp_out !== 32'h2) begin
      fails++; $display("FAIL bp_req0_rsp: got valid %b out %h expected 01 2", rsp_valid, rsp_out); end
    $display("[TB] txn req0 ADD 1+1 -> %h", rsp_out);
  endtask

  task automatic test_fairness;
    int grants[$];
    int nresp0 = 0;
    int nresp1 = 0;
    apply_reset;
    tick;
    req_valid = 2'b11; rsp_ready = 2'b11;
    op0 = OP_ADD; a0 = 32'd10;  b0 = 32'd20;
    op1 = OP_SUB; a1 = 32'd100; b1 = 32'd1;
    for (int c = 0; c < 80 && (nresp0 + nresp1) < 8; c++) begin
      #1;
      if (req_ready == 2'b01) grants.push_back(0);
      if (req_ready == 2'b10) grants.push_back(1);
      if (rsp_valid == 2'b01) begin
        nresp0++;
        tests++; if (rsp_out !== 32'd30) begin fails++; $display("FAIL fair_rsp0: got %h expected 1e", rsp_out); end
        $display("[TB] txn fair req0 ADD 10+20 -> %0d", rsp_out);
      end
      if (rsp_valid == 2'b10) begin
        nresp1++;
        tests++; if (rsp_out !== 32'd99) begin fails++; $display("FAIL fair_rsp1: got %h expected 63", rsp_out); end
        $display("[TB] txn fair req1 SUB 100-1 -> %0d", rsp_out);
      end
      tick;
    end
    req_valid = 2'b00;
    tests++; if (nresp0 !== 4 || nresp1 !== 4) begin
      fails++; $display("FAIL fair_counts: got %0d/%0d expected 4/4", nresp0, nresp1); end
    tests++; if (grants.size() < 8) begin
      fails++; $display("FAIL fair_grant_count: got %0d expected 8", grants.size()); end
    for (int i = 0; i < 8 && i < grants.size(); i++) begin
      tests++; if (grants[i] !== (i % 2)) begin
        fails++; $display("FAIL fair_order[%0d]: got %0d expected %0d", i, grants[i], i % 2); end
    end
  endtask

  task automatic test_reset_midop;
    apply_reset;
    tick;
    req_valid = 2'b01; op0 = OP_ADD; a0 = 32'h4; b0 = 32'h4; rsp_ready = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL midrst_accept: got %b expected 01", req_ready); end
    tick;
    req_valid = 2'b00;
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_exec_busy: got %b expected 1", busy); end
    RST = 1'b1;
    tick;
    RST = 1'b0;
    #1;
    tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin
      fails++; $display("FAIL midrst_after: got valid %b busy %b ready %b expected 00 0 00", rsp_valid, busy, req_ready); end
    tests++; if (alu_op !== 4'h0 || alu_porta !== 32'h0 || alu_portb !== 32'h0 || rsp_out !== 32'h0) begin
      fails++; $display("FAIL midrst_outputs: got %h %h %h %h expected all 0", alu_op, alu_porta, alu_portb, rsp_out); end
    for (int c = 0; c < 4; c++) begin
      tick; #1;
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL midrst_no_rsp: got %b expected 00", rsp_valid); end
    end
    tick;
    req_valid = 2'b01; op0 = OP_ADD; a0 = 32'h9; b0 = 32'h1;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL midrst_fresh_accept: got %b expected 01", req_ready); end
    tick;
    req_valid = 2'b00;
    tick; #1;
    tests++; if (rsp_valid !== 2'b01 || rsp_out !== 32'hA) begin
      fails++; $display("FAIL midrst_fresh_rsp: got valid %b out %h expected 01 a", rsp_valid, rsp_out); end
    $display("[TB] txn req0 ADD 9+1 after reset -> %h", rsp_out);
  endtask

  initial begin
    test_reset;
    test_single;
    test_simultaneous;
    test_backpressure;
    test_fairness;
    test_reset_midop;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
